// File: rtl/irq_ctrl_multi_if.sv
// irq_ctrl_multi_if: CPU/config-side bundle of the multi-channel interrupt controller
interface irq_ctrl_multi_if #(
  parameter int NUM_IRQ = 8,
  parameter int ID_W = 3
);
  logic [NUM_IRQ-1:0] irq_in;
  logic               csr_meie;
  logic               cfg_we;
  logic [1:0]         cfg_addr;
  logic [NUM_IRQ-1:0] cfg_wdata;
  logic [NUM_IRQ-1:0] cfg_rdata;
  logic               claim;
  logic               complete;
  logic [ID_W-1:0]    complete_id;
  logic               g_interrupt;
  logic [ID_W-1:0]    irq_id;
  modport master (
    output irq_in, csr_meie, cfg_we, cfg_addr, cfg_wdata, claim, complete, complete_id,
    input  cfg_rdata, g_interrupt, irq_id
  );
  modport slave (
    input  irq_in, csr_meie, cfg_we, cfg_addr, cfg_wdata, claim, complete, complete_id,
    output cfg_rdata, g_interrupt, irq_id
  );
endinterface

// File: rtl/irq_ctrl_multi.sv
// irq_ctrl_multi: synchronised edge/level interrupt sources, fixed priority, claim/complete tracking
module irq_ctrl_multi #(
  parameter int NUM_IRQ = 8,
  parameter int SYNC_STAGES = 2,
  parameter int ID_W = 3
) (
  input logic clk,
  input logic rst,
  irq_ctrl_multi_if.slave bus
);
  logic [SYNC_STAGES-1:0][NUM_IRQ-1:0] r_sync;
  logic [NUM_IRQ-1:0] r_hist, r_en, r_mode, r_pend, r_insvc;
  logic               r_g_int;
  logic [ID_W-1:0]    r_id;
  logic [NUM_IRQ-1:0] w_sync, w_active, w_claim_vec, w_cmp_vec, w_w1c, w_to_edge, w_pend_nxt;
  logic               w_acc, w_wr_en, w_wr_mode, w_wr_pend;
  logic [ID_W-1:0]    w_id;

  assign w_sync    = r_sync[SYNC_STAGES-1];
  assign w_acc     = bus.claim & r_g_int;
  assign w_wr_en   = bus.cfg_we & (bus.cfg_addr == 2'd0);
  assign w_wr_mode = bus.cfg_we & (bus.cfg_addr == 2'd1);
  assign w_wr_pend = bus.cfg_we & (bus.cfg_addr == 2'd2);
  assign w_active  = r_pend & r_en & ~r_insvc;
  // IDs at or above NUM_IRQ shift out of the vector, so they complete nothing
  assign w_claim_vec = w_acc ? NUM_IRQ'(1) << r_id : '0;
  assign w_cmp_vec   = bus.complete ? NUM_IRQ'(1) << bus.complete_id : '0;
  assign w_w1c       = w_wr_pend ? bus.cfg_wdata : '0;
  assign w_to_edge   = w_wr_mode ? bus.cfg_wdata & ~r_mode : '0;
  // edge channels latch rising edges (set beats clear); level channels mirror sync; level->edge starts clean
  assign w_pend_nxt  = ~w_to_edge & ((r_mode & ((w_sync & ~r_hist) | (r_pend & ~(w_w1c | w_claim_vec))))
                                     | (~r_mode & w_sync));

  // lowest active index wins
  always_comb begin
    w_id = '0;
    for (int k = NUM_IRQ - 1; k >= 0; k--) if (w_active[k]) w_id = ID_W'(k);
  end

  // combinational register readback
  always_comb begin
    bus.cfg_rdata = bus.cfg_addr == 2'd0 ? r_en :
                    bus.cfg_addr == 2'd1 ? r_mode :
                    bus.cfg_addr == 2'd2 ? r_pend : r_insvc;
  end

  // synchronisers, channel state and the registered request to the core
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync  <= '0;
      r_hist  <= '0;
      r_en    <= '0;
      r_mode  <= '0;
      r_pend  <= '0;
      r_insvc <= '0;
      r_g_int <= 1'b0;
      r_id    <= '0;
    end else begin
      r_sync  <= {r_sync[SYNC_STAGES-2:0], bus.irq_in};
      r_hist  <= w_sync;
      r_en    <= w_wr_en ? bus.cfg_wdata : r_en;
      r_mode  <= w_wr_mode ? bus.cfg_wdata : r_mode;
      r_pend  <= w_pend_nxt;
      r_insvc <= (r_insvc & ~w_cmp_vec) | w_claim_vec;
      r_g_int <= bus.csr_meie & |w_active;
      r_id    <= w_id;
    end
  end

  assign bus.g_interrupt = r_g_int;
  assign bus.irq_id      = r_id;
endmodule

// File: tb/tb_irq_ctrl_multi.sv
// tb_irq_ctrl_multi: directed scoreboard bench for irq_ctrl_multi
module tb_irq_ctrl_multi;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int errors = 0;
  logic [31:0] sb[$];

  irq_ctrl_multi_if #(.NUM_IRQ(8), .ID_W(3)) bus ();
  irq_ctrl_multi #(.NUM_IRQ(8), .SYNC_STAGES(2), .ID_W(3)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic ex(input logic [31:0] v);
    sb.push_back(v);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL %s scoreboard empty, observed %0h", tag, obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e) else begin
        errors++;
        $error("FAIL %s observed %0h expected %0h", tag, obs, e);
      end
    end
  endtask

  task automatic rdchk(input string tag, input logic [1:0] a);
    bus.cfg_addr = a;
    #1;
    chk(tag, 32'(bus.cfg_rdata));
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    bus.cfg_we = 1'b1;
    bus.cfg_addr = a;
    bus.cfg_wdata = d;
    tick();
    bus.cfg_we = 1'b0;
  endtask

  task automatic do_claim();
    bus.claim = 1'b1;
    tick();
    bus.claim = 1'b0;
  endtask

  task automatic do_complete(input logic [2:0] id);
    bus.complete = 1'b1;
    bus.complete_id = id;
    tick();
    bus.complete = 1'b0;
  endtask

  initial begin
    bus.irq_in = '0;
    bus.csr_meie = 1'b0;
    bus.cfg_we = 1'b0;
    bus.cfg_addr = '0;
    bus.cfg_wdata = '0;
    bus.claim = 1'b0;
    bus.complete = 1'b0;
    bus.complete_id = '0;
    rst = 1'b1;
    #12;
    ex(0); chk("rst_gint", 32'(bus.g_interrupt));
    ex(0); chk("rst_id", 32'(bus.irq_id));
    ex(0); rdchk("rst_pend", 2);
    rst = 1'b0;
    bus.csr_meie = 1'b1;
    // edge path on channel 0
    wr(0, 8'hFF);
    wr(1, 8'h01);
    bus.irq_in[0] = 1'b1; tick(); bus.irq_in[0] = 1'b0; tick();
    ex(0); rdchk("edge_pend_e2", 2);
    tick();
    ex(8'h01); rdchk("edge_pend_e3", 2);
    ex(0); chk("edge_gint_e3", 32'(bus.g_interrupt));
    tick();
    ex(1); chk("edge_gint_e4", 32'(bus.g_interrupt));
    ex(0); chk("edge_id_e4", 32'(bus.irq_id));
    do_claim();
    ex(0); rdchk("edge_claim_pend", 2);
    ex(8'h01); rdchk("edge_claim_insvc", 3);
    tick();
    ex(0); chk("edge_claim_gint", 32'(bus.g_interrupt));
    do_complete(0);
    ex(0); rdchk("edge_cmp_insvc", 3);
    // priority and nesting with level sources 2 and 5
    wr(0, 8'h24);
    bus.irq_in[2] = 1'b1; bus.irq_in[5] = 1'b1;
    repeat (4) tick();
    ex(1); chk("prio_gint", 32'(bus.g_interrupt));
    ex(2); chk("prio_id", 32'(bus.irq_id));
    do_claim(); tick();
    ex(1); chk("nest_gint", 32'(bus.g_interrupt));
    ex(5); chk("nest_id", 32'(bus.irq_id));
    do_claim();
    ex(8'h24); rdchk("nest_insvc", 3);
    tick();
    ex(0); chk("nest_gint_off", 32'(bus.g_interrupt));
    do_complete(2); tick();
    ex(1); chk("nest_reassert_gint", 32'(bus.g_interrupt));
    ex(2); chk("nest_reassert_id", 32'(bus.irq_id));
    bus.irq_in = '0;
    do_complete(5);
    repeat (4) tick();
    ex(0); chk("nest_clean_gint", 32'(bus.g_interrupt));
    ex(0); rdchk("nest_clean_insvc", 3);
    // masking and global enable
    wr(1, 8'h11);
    wr(0, 8'h0F);
    bus.irq_in[4] = 1'b1; tick(); bus.irq_in[4] = 1'b0;
    repeat (3) tick();
    ex(8'h10); rdchk("mask_pend", 2);
    ex(0); chk("mask_gint", 32'(bus.g_interrupt));
    wr(0, 8'h1F); tick();
    ex(1); chk("unmask_gint", 32'(bus.g_interrupt));
    ex(4); chk("unmask_id", 32'(bus.irq_id));
    bus.csr_meie = 1'b0; tick();
    ex(0); chk("meie_off_gint", 32'(bus.g_interrupt));
    ex(8'h10); rdchk("meie_off_pend", 2);
    bus.csr_meie = 1'b1; tick();
    ex(1); chk("meie_on_gint", 32'(bus.g_interrupt));
    do_claim();
    do_complete(4);
    ex(0); rdchk("mask_done_insvc", 3);
    ex(0); rdchk("mask_done_pend", 2);
    // W1C colliding with a new edge, and claim+complete of the same ID
    bus.irq_in[0] = 1'b1; tick(); bus.irq_in[0] = 1'b0; tick();
    wr(2, 8'h01);
    ex(8'h01); rdchk("w1c_vs_set_pend", 2);
    tick();
    ex(1); chk("w1c_vs_set_gint", 32'(bus.g_interrupt));
    ex(0); chk("w1c_vs_set_id", 32'(bus.irq_id));
    bus.claim = 1'b1; bus.complete = 1'b1; bus.complete_id = 3'd0;
    tick();
    bus.claim = 1'b0; bus.complete = 1'b0;
    ex(8'h01); rdchk("clm_cmp_insvc", 3);
    ex(0); rdchk("clm_cmp_pend", 2);
    do_complete(0);
    ex(0); rdchk("cmp0_insvc", 3);
    // claim while g_interrupt is low is ignored
    bus.csr_meie = 1'b0;
    bus.irq_in[0] = 1'b1; tick(); bus.irq_in[0] = 1'b0;
    repeat (2) tick();
    ex(8'h01); rdchk("ign_pend_pre", 2);
    ex(0); chk("ign_gint", 32'(bus.g_interrupt));
    do_claim();
    ex(8'h01); rdchk("ign_pend", 2);
    ex(0); rdchk("ign_insvc", 3);
    wr(2, 8'h01);
    ex(0); rdchk("w1c_pend", 2);
    bus.csr_meie = 1'b1;
    // level channel 6: re-interrupt after complete, then drop latency
    wr(0, 8'h5F);
    bus.irq_in[6] = 1'b1;
    repeat (4) tick();
    ex(1); chk("lvl_gint", 32'(bus.g_interrupt));
    ex(6); chk("lvl_id", 32'(bus.irq_id));
    do_claim(); tick();
    ex(0); chk("lvl_claim_gint", 32'(bus.g_interrupt));
    do_complete(6); tick();
    ex(1); chk("lvl_reint_gint", 32'(bus.g_interrupt));
    ex(6); chk("lvl_reint_id", 32'(bus.irq_id));
    bus.irq_in[6] = 1'b0;
    repeat (3) tick();
    ex(1); chk("lvl_drop_e3", 32'(bus.g_interrupt));
    tick();
    ex(0); chk("lvl_drop_e4", 32'(bus.g_interrupt));
    // asynchronous reset mid-operation
    wr(1, 8'h08);
    wr(0, 8'h0A);
    bus.irq_in[1] = 1'b1;
    repeat (4) tick();
    ex(1); chk("pre_rst_id1", 32'(bus.irq_id));
    do_claim();
    ex(8'h02); rdchk("pre_rst_insvc", 3);
    bus.irq_in[3] = 1'b1; tick(); bus.irq_in[3] = 1'b0;
    repeat (3) tick();
    ex(8'h0A); rdchk("pre_rst_pend", 2);
    ex(1); chk("pre_rst_gint", 32'(bus.g_interrupt));
    ex(3); chk("pre_rst_id3", 32'(bus.irq_id));
    rst = 1'b1;
    #1;
    ex(0); chk("arst_gint", 32'(bus.g_interrupt));
    ex(0); chk("arst_id", 32'(bus.irq_id));
    ex(0); rdchk("arst_en", 0);
    ex(0); rdchk("arst_mode", 1);
    ex(0); rdchk("arst_pend", 2);
    ex(0); rdchk("arst_insvc", 3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
